ads_adc_emulator: RTL and testbench

//  Synthesisable, parametrised ADS8568-style serial ADC emulator (convst/busy/fs_n/sclk/sdo).

---
 rtl/ads_emu_pkg.sv | 25 ++
 rtl/ads_emu_lane.sv | 71 +++++++
 rtl/ads_adc_emulator.sv | 164 ++++++++++++++++
 tb/tb_ads_adc_emulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ads_emu_pkg.sv
// rtl/ads_emu_pkg.sv - shared types, LFSR constants and ramp helper for the ADS-style ADC emulator
// Optional LFSR data pattern is built only when ADS_EMU_LFSR_EN is defined.
package ads_emu_pkg;

  typedef enum logic [2:0] {IDLE, CONV, READY, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {MODE_RAMP, MODE_FIXED, MODE_LFSR} mode_t;

  // Per-lane seed is LFSR_SEED ^ lane.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  // Channel index in the top nibble, frame count (zero-extended) below it.
  function automatic logic [31:0] ramp_word(input int unsigned sample_w, input logic [3:0] c,
                                            input logic [15:0] frame_cnt);
    logic [31:0] low_mask;
    low_mask = (32'd1 << (sample_w - 4)) - 32'd1;
    return ({16'd0, frame_cnt} & low_mask) | ({28'd0, c} << (sample_w - 4));
  endfunction

endpackage

// File: rtl/ads_emu_lane.sv
// rtl/ads_emu_lane.sv - one SDO lane: frame shift register plus optional per-lane LFSR
// The LFSR register and its step logic exist only when ADS_EMU_LFSR_EN is defined.
module ads_emu_lane
  import ads_emu_pkg::*;
#(
  parameter int SAMPLE_W       = 16,
  parameter int WORDS_PER_LANE = 2,
  parameter int LANE           = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                shift,
  input  mode_t               mode,
  input  logic [SAMPLE_W-1:0] fixed,
  input  logic [15:0]         frame_cnt,
  output logic                sdo
);

  localparam int TOTAL = SAMPLE_W * WORDS_PER_LANE;

  logic [TOTAL-1:0]    sr;
  logic [TOTAL-1:0]    load_data;
  logic [SAMPLE_W-1:0] word;
`ifdef ADS_EMU_LFSR_EN
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_next;
`endif

  // Build the whole frame image; word 0 sits at the MSB end so it leaves first.
  always_comb begin
    load_data = '0;
    word      = '0;
`ifdef ADS_EMU_LFSR_EN
    lfsr_next = lfsr;
`endif
    for (int w = 0; w < WORDS_PER_LANE; w++) begin
      case (mode)
        MODE_FIXED: word = fixed;
`ifdef ADS_EMU_LFSR_EN
        MODE_LFSR: begin
          lfsr_next = lfsr_step(lfsr_next);
          word      = SAMPLE_W'(lfsr_next);
        end
`endif
        default:    word = SAMPLE_W'(ramp_word(SAMPLE_W, 4'(LANE * WORDS_PER_LANE + w), frame_cnt));
      endcase
      load_data[TOTAL-1-w*SAMPLE_W -: SAMPLE_W] = word;
    end
  end

  // Latch the frame at READY entry, then shift MSB-first on each accepted sclk fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
`ifdef ADS_EMU_LFSR_EN
      lfsr <= LFSR_SEED ^ 16'(LANE);
`endif
    end else if (load) begin
      sr <= load_data;
`ifdef ADS_EMU_LFSR_EN
      lfsr <= lfsr_next;
`endif
    end else if (shift) begin
      sr <= {sr[TOTAL-2:0], 1'b0};
    end
  end

  assign sdo = sr[TOTAL-1];

endmodule

// File: rtl/ads_adc_emulator.sv
// rtl/ads_adc_emulator.sv - ADS8568-style convst/busy/fs_n/sclk/sdo ADC emulator top
// Define ADS_EMU_LFSR_EN to make cfg_mode=2 select the per-lane LFSR pattern (otherwise ramp).
module ads_adc_emulator
  import ads_emu_pkg::*;
#(
  parameter int N_LANES        = 4,
  parameter int SAMPLE_W       = 16,
  parameter int WORDS_PER_LANE = 2,
  parameter int CONV_CYCLES    = 55
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                ad_convst,
  output logic                ad_busy,
  input  logic                ad_fs_n,
  input  logic                ad_sclk,
  output logic [N_LANES-1:0]  ad_sdo,
  input  logic [1:0]          cfg_mode,
  input  logic [SAMPLE_W-1:0] cfg_fixed,
  output logic                frame_done,
  output logic [15:0]         frame_cnt,
  output logic                err_convst,
  output logic                err_short,
  input  logic                err_clr
);

  localparam int TOTAL = SAMPLE_W * WORDS_PER_LANE;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(CONV_CYCLES + 1);

  state_t             state;
  logic [CW-1:0]      conv_cnt;
  logic [BW-1:0]      bit_cnt;
  logic               convst_q;
  logic               fs_n_q;
  logic               sclk_q;
  mode_t              mode;
  logic [N_LANES-1:0] lane_bit;

  logic convst_rise;
  logic fs_fall;
  logic fs_rise;
  logic sclk_fall;
  logic conv_last;
  logic load;
  logic shift;

  assign convst_rise = ad_convst & ~convst_q;
  assign fs_fall     = ~ad_fs_n & fs_n_q;
  assign fs_rise     = ad_fs_n & ~fs_n_q;
  assign sclk_fall   = ~ad_sclk & sclk_q;
  assign conv_last   = (state == CONV) && (conv_cnt == CW'(CONV_CYCLES - 1));
  assign load        = conv_last;
  // sclk only counts while the frame is selected; a simultaneous fs_n rise aborts instead.
  assign shift       = (state == SHIFT) && sclk_fall && !ad_fs_n;

  // Decode the configuration pattern; reserved codes fall back to ramp.
  always_comb begin
    mode = MODE_RAMP;
    case (cfg_mode)
      2'd1:    mode = MODE_FIXED;
`ifdef ADS_EMU_LFSR_EN
      2'd2:    mode = MODE_LFSR;
`endif
      default: mode = MODE_RAMP;
    endcase
  end

  // Protocol FSM with input edge registers, counters and sticky error flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      conv_cnt   <= '0;
      bit_cnt    <= '0;
      convst_q   <= 1'b0;
      fs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      ad_busy    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err_convst <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      convst_q   <= ad_convst;
      fs_n_q     <= ad_fs_n;
      sclk_q     <= ad_sclk;
      frame_done <= 1'b0;
      // Clear first so an error detected in the same cycle overrides it.
      if (err_clr) begin
        err_convst <= 1'b0;
        err_short  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (convst_rise) begin
            state    <= CONV;
            ad_busy  <= 1'b1;
            conv_cnt <= '0;
          end
        end
        CONV: begin
          if (convst_rise) err_convst <= 1'b1;
          if (conv_last) begin
            state   <= READY;
            ad_busy <= 1'b0;
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        READY: begin
          if (convst_rise) begin
            state    <= CONV;
            ad_busy  <= 1'b1;
            conv_cnt <= '0;
          end else if (fs_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (convst_rise) err_convst <= 1'b1;
          if (fs_rise) begin
            state     <= IDLE;
            err_short <= 1'b1;
          end else if (shift) begin
            if (bit_cnt == BW'(TOTAL - 1)) begin
              state      <= DONE;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (convst_rise) err_convst <= 1'b1;
          if (ad_fs_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    ads_emu_lane #(
      .SAMPLE_W      (SAMPLE_W),
      .WORDS_PER_LANE(WORDS_PER_LANE),
      .LANE          (i)
    ) u_lane (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .load     (load),
      .shift    (shift),
      .mode     (mode),
      .fixed    (cfg_fixed),
      .frame_cnt(frame_cnt),
      .sdo      (lane_bit[i])
    );
  end

  // Lanes are driven only while a frame is being shifted.
  assign ad_sdo = (state == SHIFT) ? lane_bit : '0;

endmodule

// File: tb/tb_ads_adc_emulator.sv
// tb/tb_ads_adc_emulator.sv - directed/randomized self-checking bench for ads_adc_emulator
// Expectations for cfg_mode=2 follow ADS_EMU_LFSR_EN (LFSR when defined, ramp otherwise).
module tb_ads_adc_emulator;

  localparam int NL  = 4;
  localparam int SW  = 16;
  localparam int WPL = 2;
  localparam int CC  = 55;
`ifdef ADS_EMU_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          ad_convst = 1'b0;
  logic          ad_fs_n   = 1'b1;
  logic          ad_sclk   = 1'b0;
  logic          err_clr   = 1'b0;
  logic [1:0]    cfg_mode  = 2'd0;
  logic [SW-1:0] cfg_fixed = '0;
  logic          ad_busy;
  logic [NL-1:0] ad_sdo;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic          err_convst;
  logic          err_short;

  int checks      = 0;
  int failures    = 0;
  int done_pulses = 0;
  int model_fc    = 0;
  int model_lfsr [NL];
  logic [SW-1:0] cap [NL][WPL];

  ads_adc_emulator #(
    .N_LANES(NL), .SAMPLE_W(SW), .WORDS_PER_LANE(WPL), .CONV_CYCLES(CC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ad_convst (ad_convst),
    .ad_busy   (ad_busy),
    .ad_fs_n   (ad_fs_n),
    .ad_sclk   (ad_sclk),
    .ad_sdo    (ad_sdo),
    .cfg_mode  (cfg_mode),
    .cfg_fixed (cfg_fixed),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt),
    .err_convst(err_convst),
    .err_short (err_short),
    .err_clr   (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (frame_done === 1'b1) done_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // x^16+x^14+x^13+x^11+1, one shift to the right with feedback into bit 15.
  function automatic int ref_lfsr(input int s);
    int fb;
    fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
    return ((s >> 1) | (fb << 15)) & 16'hFFFF;
  endfunction

  function automatic void model_reset();
    model_fc = 0;
    for (int l = 0; l < NL; l++) model_lfsr[l] = 16'hACE1 ^ l;
  endfunction

  // Pulse convst and count cycles with busy high; optional second pulse at loop step repulse_at.
  task automatic convert(input int repulse_at, input bit clr_with, output int cyc);
    cyc = 0;
    ad_convst = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      ad_convst = (i == repulse_at);
      err_clr   = clr_with && (i == repulse_at);
      if (ad_busy === 1'b1) cyc++;
      else if (cyc > 0) break;
    end
    ad_convst = 1'b0;
    err_clr   = 1'b0;
  endtask

  // Drop fs_n and clock nbits sclk falls, capturing each lane before every fall.
  task automatic shift_bits(input int nbits);
    for (int l = 0; l < NL; l++)
      for (int w = 0; w < WPL; w++) cap[l][w] = '0;
    ad_fs_n = 1'b0;
    tick(2);
    for (int b = 0; b < nbits; b++) begin
      for (int l = 0; l < NL; l++) cap[l][b / SW] = {cap[l][b / SW][SW-2:0], ad_sdo[l]};
      ad_sclk = 1'b1;
      tick($urandom_range(1, 3));
      ad_sclk = 1'b0;
      tick($urandom_range(1, 3));
    end
  endtask

  task automatic full_frame(input int mode, input logic [SW-1:0] fixed, input string name);
    int cyc;
    int pulses0;
    int c;
    logic [SW-1:0] e;
    pulses0   = done_pulses;
    cfg_mode  = 2'(mode);
    cfg_fixed = fixed;
    convert(-1, 1'b0, cyc);
    chk({name, " busy_cycles"}, 32'(cyc), 32'(CC));
    shift_bits(SW * WPL);
    chk({name, " sdo_in_done"}, 32'(ad_sdo), 32'd0);
    ad_fs_n = 1'b1;
    tick(3);
    for (int l = 0; l < NL; l++) begin
      for (int w = 0; w < WPL; w++) begin
        c = l * WPL + w;
        if (mode == 1) begin
          e = fixed;
        end else if (mode == 2 && LFSR_EN) begin
          model_lfsr[l] = ref_lfsr(model_lfsr[l]);
          e = SW'(model_lfsr[l]);
        end else begin
          e = SW'((c % 16) * (1 << (SW - 4)) + (model_fc % (1 << (SW - 4))));
        end
        chk($sformatf("%s lane%0d word%0d", name, l, w), 32'(cap[l][w]), 32'(e));
      end
    end
    model_fc = (model_fc + 1) % 65536;
    chk({name, " frame_cnt"}, 32'(frame_cnt), 32'(model_fc));
    chk({name, " done_pulses"}, 32'(done_pulses - pulses0), 32'd1);
  endtask

  initial begin
    int cyc;
    int pulses0;
    model_reset();
    tick(3);
    chk("reset busy", 32'(ad_busy), 32'd0);
    chk("reset sdo", 32'(ad_sdo), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset frame_cnt", 32'(frame_cnt), 32'd0);
    chk("reset err_convst", 32'(err_convst), 32'd0);
    chk("reset err_short", 32'(err_short), 32'd0);
    sys_rst_n = 1'b1;
    tick(2);

    full_frame(0, '0, "ramp0");
    full_frame(0, '0, "ramp1");
    full_frame(3, '0, "reserved");
    full_frame(1, 16'hA5C3, "fixed_a5c3");
    full_frame(1, 16'($urandom), "fixed_rand");

    // Short frame after 10 falls.
    pulses0 = done_pulses;
    convert(-1, 1'b0, cyc);
    shift_bits(10);
    ad_fs_n = 1'b1;
    tick(3);
    chk("short err_short", 32'(err_short), 32'd1);
    chk("short frame_cnt", 32'(frame_cnt), 32'(model_fc));
    chk("short sdo", 32'(ad_sdo), 32'd0);
    chk("short no_done", 32'(done_pulses - pulses0), 32'd0);
    // Back in IDLE: fs_n/sclk activity shifts nothing, convst is accepted without error.
    ad_fs_n = 1'b0;
    tick(2);
    ad_sclk = 1'b1;
    tick(2);
    ad_sclk = 1'b0;
    tick(2);
    chk("idle sdo", 32'(ad_sdo), 32'd0);
    ad_fs_n = 1'b1;
    tick(2);
    convert(-1, 1'b0, cyc);
    chk("idle convst busy", 32'(cyc), 32'(CC));
    chk("idle convst no_err", 32'(err_convst), 32'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_short cleared", 32'(err_short), 32'd0);

    // Random-length short frame from READY.
    shift_bits($urandom_range(1, SW * WPL - 1));
    ad_fs_n = 1'b1;
    tick(3);
    chk("rand short err_short", 32'(err_short), 32'd1);
    chk("rand short frame_cnt", 32'(frame_cnt), 32'(model_fc));
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;

    // convst during conversion flags an error but does not stretch busy.
    convert(20, 1'b0, cyc);
    chk("conv repulse busy", 32'(cyc), 32'(CC));
    chk("conv repulse err_convst", 32'(err_convst), 32'd1);
    // convst in READY restarts cleanly.
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_convst cleared", 32'(err_convst), 32'd0);
    convert(-1, 1'b0, cyc);
    chk("ready restart busy", 32'(cyc), 32'(CC));
    chk("ready restart no_err", 32'(err_convst), 32'd0);
    // Error beats a simultaneous clear.
    convert(20, 1'b1, cyc);
    chk("err wins over clr", 32'(err_convst), 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    full_frame(0, '0, "ramp_after_restart");

    // Asynchronous reset in the middle of a frame.
    convert(-1, 1'b0, cyc);
    shift_bits(12);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midreset sdo", 32'(ad_sdo), 32'd0);
    chk("midreset busy", 32'(ad_busy), 32'd0);
    chk("midreset frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midreset err_short", 32'(err_short), 32'd0);
    ad_fs_n = 1'b1;
    tick(2);
    sys_rst_n = 1'b1;
    model_reset();
    tick(2);

    full_frame(2, '0, "mode2_a");
    chk("mode2 lane0 word0", 32'(cap[0][0]), LFSR_EN ? 32'h5670 : 32'h0000);
    full_frame(2, '0, "mode2_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
